// File: rtl/gpr_pkg.sv
// Shared types and default sizes for the GPR file with pending-write scoreboard.
package gpr_pkg;
  localparam int GPR_DATA_W = 32;
  localparam int GPR_ADDR_W = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } gpr_state_e;
endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register pending bits: set on issue, cleared by writeback or by the clear sweep.
module gpr_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    set_v,
  input  logic [ADDR_W-1:0]       set_a,
  input  logic                    clr_v,
  input  logic [ADDR_W-1:0]       clr_a,
  input  logic                    swp_v,
  input  logic [ADDR_W-1:0]       swp_a,
  input  logic [NREAD*ADDR_W-1:0] look_a,
  output logic [NREAD-1:0]        pend
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pend_q, pend_d;

  // Set is applied after clear so a same-cycle issue (newer producer) wins.
  always_comb begin
    pend_d = pend_q;
    if (swp_v) begin
      pend_d[swp_a] = 1'b0;
    end else begin
      if (clr_v) pend_d[clr_a] = 1'b0;
      if (set_v) pend_d[set_a] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_look
    assign pend[i] = pend_q[look_a[i*ADDR_W +: ADDR_W]];
  end
endmodule

// File: rtl/gpr_file_sb.sv
// Byte-enabled register file with combinational reads, write forwarding,
// pending-write scoreboard and a one-register-per-cycle clear sweep.
module gpr_file_sb
  import gpr_pkg::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int ADDR_W = GPR_ADDR_W,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       wa,
  input  logic [DATA_W-1:0]       wd,
  input  logic [DATA_W/8-1:0]     wbe,
  input  logic [31:0]             pc,
  input  logic [NREAD*ADDR_W-1:0] ra,
  output logic [NREAD*DATA_W-1:0] rd,
  output logic [NREAD-1:0]        rd_pend,
  input  logic                    iss_v,
  input  logic [ADDR_W-1:0]       iss_a,
  input  logic                    clr_req,
  output logic                    clr_busy
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  gpr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] merged;
  logic              wr_eff;
  logic [NREAD-1:0]  pend_raw;

  assign clr_busy = (state_q == SWEEP);
  assign wr_eff   = we && (wa != '0) && !clr_busy;

  always_comb begin
    merged = data_q[wa];
    for (int b = 0; b < NB; b++)
      if (wbe[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (clr_req) begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
      SWEEP: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (clr_busy)    data_q[cnt_q] <= '0;
      else if (wr_eff) data_q[wa]    <= merged;
    end
  end

  gpr_scoreboard #(.ADDR_W(ADDR_W), .NREAD(NREAD)) u_sb (
    .clk    (clk),
    .reset  (reset),
    .set_v  (iss_v && !clr_busy && (iss_a != '0)),
    .set_a  (iss_a),
    .clr_v  (wr_eff),
    .clr_a  (wa),
    .swp_v  (clr_busy),
    .swp_a  (cnt_q),
    .look_a (ra),
    .pend   (pend_raw)
  );

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit;
    assign a   = ra[i*ADDR_W +: ADDR_W];
    assign hit = (BYPASS != 0) && wr_eff && (wa == a);
    assign rd[i*DATA_W +: DATA_W] = (a == '0) ? '0 : (hit ? merged : data_q[a]);
    assign rd_pend[i] = clr_busy | (~hit & pend_raw[i]);
  end

`ifndef SYNTHESIS
  always @(posedge clk)
    if (!reset && wr_eff) $display("@%h: $%d <= %h", pc, wa, merged);
`endif
endmodule

// File: doc/gpr_file_sb.md
GPR_FILE_SB -- requirements
Module: gpr_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits; a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter NREAD, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding is enabled.
REQ-005 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  meaning synchronous, active-high reset.
REQ-007 SHALL have port we  in  1  meaning write request.
REQ-008 SHALL have port wa  in  ADDR_W  meaning write address.
REQ-009 SHALL have port wd  in  DATA_W  meaning write data.
REQ-010 SHALL have port wbe  in  DATA_W/8  meaning per-byte write enable.
REQ-011 SHALL have port pc  in  32  meaning instruction address, used for the trace only.
REQ-012 SHALL have port ra  in  NREAD*ADDR_W  meaning read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-013 SHALL have port rd  out  NREAD*DATA_W  meaning read data, packed like ra.
REQ-014 SHALL have port rd_pend  out  NREAD  meaning the addressed register awaits an outstanding write.
REQ-015 SHALL have port iss_v  in  1  meaning issue-valid: mark iss_a pending.
REQ-016 SHALL have port iss_a  in  ADDR_W  meaning address to mark pending.
REQ-017 SHALL have port clr_req  in  1  meaning start a clear sweep.
REQ-018 SHALL have port clr_busy  out  1  meaning a clear sweep is in progress.

Function
REQ-019 Reads SHALL be combinational; rd[i] = 0 when ra[i]==0, otherwise the stored word.
REQ-020 With BYPASS=1, we=1, wa==ra[i]!=0 and clr_busy=0, rd[i] SHALL be the merged word: wd bytes where wbe is set, stored bytes elsewhere.
REQ-021 An effective write (we=1, wa!=0, clr_busy=0) SHALL update only the bytes selected by wbe at the clock edge; wbe==0 leaves data unchanged.
REQ-022 Register 0 SHALL read 0 and SHALL never become pending; writes and issues to it are ignored.
REQ-023 Each effective write SHALL emit a simulation-only trace line "@<pc hex>: $<wa decimal> <= <merged word hex>"; this trace is not synthesised.
REQ-024 Pending bit pend[a] SHALL set at the edge when iss_v=1 and iss_a==a!=0, and clear at the edge when an effective write targets a, regardless of wbe.
REQ-025 Simultaneous issue and write to the same address SHALL leave pend set: the newer producer wins.
REQ-026 rd_pend[i] SHALL be pend[ra[i]], forced 0 when BYPASS=1 and the same-cycle effective write targets ra[i]; it SHALL be forced 1 for every port while clr_busy=1.
REQ-027 The FSM SHALL have states IDLE and SWEEP; clr_req in IDLE moves to SWEEP with cnt=0; clr_req in SWEEP is ignored.
REQ-028 In SWEEP, each cycle SHALL zero data[cnt] and pend[cnt] and increment cnt; at cnt==DEPTH-1 the FSM SHALL return to IDLE, so a sweep lasts exactly DEPTH cycles.
REQ-029 clr_busy SHALL be 1 exactly while in SWEEP; writes and issues during SWEEP SHALL be dropped.

Reset
REQ-030 reset=1 at an edge SHALL zero all data and pend bits, set the FSM to IDLE and cnt to 0, and has priority over all other inputs.
REQ-031 Reset during SWEEP SHALL abort the sweep; clr_busy SHALL be 0 in the following cycle.
REQ-032 After reset, all rd SHALL be 0, all rd_pend 0 and clr_busy 0.

Structure
REQ-033 Package gpr_pkg SHALL hold the FSM state enum (IDLE, SWEEP) and the default DATA_W/ADDR_W constants.
REQ-034 Pending-bit logic SHALL be the sub-module gpr_scoreboard (ports: clk, reset, set/clear/sweep-clear controls, lookup addresses, pend outputs).

Verification
REQ-035 Write wa=3, wd=0x12345678, wbe=0xF; next cycle ra0=3 -> rd0=0x12345678, trace "@<pc>: $ 3 <= 12345678".
REQ-036 Reg3=0x12345678; same cycle we, wa=3, wd=0xAABBCCDD, wbe=0x3, ra1=3 -> rd1=0x1234CCDD combinationally (BYPASS=1) and stored after the edge.
REQ-037 Issue 5; next cycle ra0=5 -> rd_pend0=1; write 5 -> rd_pend0=0 in that cycle, and pend stays 0 after; issue and write 5 together -> pend remains 1.
REQ-038 Write wa=0, wd=0xFFFFFFFF -> rd=0 at ra=0 and no trace line.
REQ-039 clr_req with DEPTH=32 -> clr_busy=1 for exactly 32 cycles, all rd_pend=1 meanwhile; afterwards all registers read 0; a write during the sweep is lost.
REQ-040 Assert reset in sweep cycle 10 -> clr_busy=0 the next cycle, all registers 0, FSM in IDLE.
